// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the single-outstanding imem handshake
// and holds each returned word until the instruction queue takes it.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iq_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign fetch_pc    = pc_q;
  assign fetch_instr = instr_q;
  // Redirect gates the offer so a wrong-path word can never be accepted.
  assign fetch_valid = (state_q == StHold) && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        StIdle:  state_q <= StReq;
        // A grant in this cycle means a response for the old pc is still coming.
        StReq:   state_q <= imem_gnt ? StDrain : StReq;
        StWait:  state_q <= imem_rvalid ? StReq : StDrain;
        StHold:  state_q <= StReq;
        StDrain: state_q <= StDrain;
        default: state_q <= StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (imem_gnt) state_q <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (!iq_full) begin
            pc_q    <= pred_taken ? pred_target : pc_q + 32'd4;
            state_q <= StReq;
          end
        end
        StDrain: begin
          if (imem_rvalid) state_q <= StReq;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a flag-based transaction model plus a
// one-outstanding memory with random grant and response latency.
module tb_fetch_ctrl;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iq_full, redirect_valid, pred_taken, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, pred_target, imem_rdata;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, fetch_pc, fetch_instr;

  fetch_ctrl #(.RESET_PC(RstPc)) dut (
    .clk           (clk),
    .reset         (reset),
    .iq_full       (iq_full),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_instr   (fetch_instr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: idle = first cycle out of reset; outstanding = granted request in flight;
  // wrong_path = that response must be dropped; held = word waiting for the queue.
  bit          m_idle, m_out, m_wrong, m_held;
  logic [31:0] m_pc, m_instr;
  int          mem_cnt;
  logic [31:0] mem_data;

  int p_gnt, p_full, p_redir, p_pred, p_spur, lat_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0403;
      3:       return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_out   = 1'b0;
    m_wrong = 1'b0;
    m_held  = 1'b0;
    m_pc    = RstPc;
    m_instr = 32'h0;
    mem_cnt = 0;
  endtask

  task automatic quiet_inputs();
    iq_full        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    pred_taken     = 1'b0;
    pred_target    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
  endtask

  task automatic drive_inputs();
    imem_gnt   = chance(p_gnt);
    imem_rdata = $urandom;
    if (mem_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data;
    end else begin
      // Stray responses only when nothing is in flight; they must be ignored.
      imem_rvalid = !m_out && chance(p_spur);
    end
    iq_full        = chance(p_full);
    redirect_valid = chance(p_redir);
    // Redirect while draining on the response cycle would wait for a response
    // that never comes; keep the stimulus out of that corner.
    if (m_out && m_wrong && imem_rvalid) redirect_valid = 1'b0;
    redirect_pc = pick_addr();
    pred_taken  = chance(p_pred);
    pred_target = pick_addr();
  endtask

  task automatic check_outputs();
    check("imem_req", {31'b0, imem_req}, {31'b0, !m_idle && !m_out && !m_held});
    check("imem_addr", imem_addr, m_pc);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_held && !redirect_valid});
    check("fetch_pc", fetch_pc, m_pc);
    check("fetch_instr", fetch_instr, m_instr);
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    bit          req_now;
    req_now = !m_idle && !m_out && !m_held;
    nxt     = m_pc;
    if (redirect_valid) nxt = {redirect_pc[31:2], 2'b00};
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_held) begin
      if (redirect_valid) m_held = 1'b0;
      else if (!iq_full) begin
        m_held = 1'b0;
        nxt    = pred_taken ? pred_target : m_pc + 32'd4;
      end
    end else if (m_out) begin
      if (m_wrong) begin
        if (imem_rvalid && !redirect_valid) m_out = 1'b0;
      end else if (imem_rvalid) begin
        m_out = 1'b0;
        if (!redirect_valid) begin
          m_held  = 1'b1;
          m_instr = imem_rdata;
        end
      end else if (redirect_valid) begin
        m_wrong = 1'b1;
      end
    end else if (imem_gnt) begin
      m_out   = 1'b1;
      m_wrong = redirect_valid;
    end
    m_pc = nxt;
    if (mem_cnt > 0) mem_cnt--;
    if (req_now && imem_gnt) begin
      mem_cnt  = int'($urandom_range(1, lat_max));
      mem_data = $urandom;
    end
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    quiet_inputs();
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    quiet_inputs();
    #1;
    reset = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 0) begin
        // Ideal memory, no stalls or redirects: plain sequential stream.
        p_gnt = 100; p_full = 0; p_redir = 0; p_pred = 0; p_spur = 0; lat_max = 1;
      end else if (cyc % 300 == 0) begin
        p_gnt   = int'($urandom_range(30, 100));
        p_full  = int'($urandom_range(0, 85));
        p_redir = int'($urandom_range(0, 25));
        p_pred  = int'($urandom_range(0, 60));
        p_spur  = int'($urandom_range(0, 10));
        lat_max = int'($urandom_range(1, 5));
      end
      @(negedge clk);
      drive_inputs();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      if (cyc == 2000) async_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
